// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART serial transmitter, LSB-first, 11 bit times per frame.
// Latency: LOAD sampled at edge n+1 drops TXRDY; start bit at edge n+2; TXRDY
//   returns 11 x rate clocks after the start bit begins.
// Backpressure: LOAD is honoured only while TXRDY=1; LOAD while busy is dropped.
//
// Ports:
//   clk       100 MHz system clock
//   rst       asynchronous active-high reset
//   baud      baud select code (bit time table shared with the receive engine)
//   EIGHT     1 = 8 data bits, 0 = 7 data bits
//   PEN       parity enable
//   OHEL      parity sense, 1 = odd, 0 = even
//   LOAD      single-cycle write strobe qualifying OUT_PORT
//   OUT_PORT  byte to transmit
//   TX        serial output, idle high, driven straight from a flop
//   TXRDY     engine idle and able to accept LOAD
module uart_tx_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       LOAD,
  input  logic [7:0] OUT_PORT,
  output logic       TX,
  output logic       TXRDY
);

  // Frame length is fixed; short formats pad with extra stop bits.
  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADSR = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    txrdy_q;
  logic [FRAME_BITS-1:0]   sr_q;
  logic [CNT_W-1:0]        bt_cnt_q;
  logic [3:0]              bit_cnt_q;
  logic [7:0]              data_q;
  logic                    eight_q;
  logic                    pen_q;
  logic                    ohel_q;
  logic [CNT_W-1:0]        rate_m1_q;

  logic [CNT_W-1:0]        rate_m1_d;
  logic [FRAME_BITS-1:0]   frame_d;
  logic                    parity_d;
  logic                    btu;

  // Bit time in clocks minus one, so the compare against the counter is direct.
  always_comb begin
    rate_m1_d = CNT_W'(333333 - 1);
    case (baud)
      4'h0: rate_m1_d = CNT_W'(333333 - 1);
      4'h1: rate_m1_d = CNT_W'(83333 - 1);
      4'h2: rate_m1_d = CNT_W'(41667 - 1);
      4'h3: rate_m1_d = CNT_W'(20833 - 1);
      4'h4: rate_m1_d = CNT_W'(10417 - 1);
      4'h5: rate_m1_d = CNT_W'(5208 - 1);
      4'h6: rate_m1_d = CNT_W'(2604 - 1);
      4'h7: rate_m1_d = CNT_W'(1736 - 1);
      4'h8: rate_m1_d = CNT_W'(868 - 1);
      4'h9: rate_m1_d = CNT_W'(434 - 1);
      4'hA: rate_m1_d = CNT_W'(217 - 1);
      4'hB: rate_m1_d = CNT_W'(109 - 1);
      default: rate_m1_d = CNT_W'(333333 - 1);
    endcase
  end

  // Frame image built from the latched byte and configuration.
  always_comb begin
    parity_d = (eight_q ? (^data_q) : (^data_q[6:0])) ^ ohel_q;
    frame_d       = '1;
    frame_d[0]    = 1'b0;
    frame_d[7:1]  = data_q[6:0];
    if (eight_q) begin
      frame_d[8] = data_q[7];
      frame_d[9] = pen_q ? parity_d : 1'b1;
    end else begin
      frame_d[8] = pen_q ? parity_d : 1'b1;
    end
  end

  assign btu = (state_q == SHIFT) && (bt_cnt_q == rate_m1_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      txrdy_q   <= 1'b1;
      sr_q      <= '1;
      bt_cnt_q  <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      rate_m1_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (LOAD) begin
            data_q    <= OUT_PORT;
            eight_q   <= EIGHT;
            pen_q     <= PEN;
            ohel_q    <= OHEL;
            rate_m1_q <= rate_m1_d;
            txrdy_q   <= 1'b0;
            state_q   <= LOADSR;
          end
        end
        LOADSR: begin
          sr_q      <= frame_d;
          bt_cnt_q  <= '0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (btu) begin
            // After the 11th shift the register holds only fill ones, so TX
            // is already idle-high when TXRDY rises on this same edge.
            sr_q      <= {1'b1, sr_q[FRAME_BITS-1:1]};
            bt_cnt_q  <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
              txrdy_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            bt_cnt_q <= bt_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txrdy_q <= 1'b1;
          sr_q    <= '1;
        end
      endcase
    end
  end

  assign TX    = sr_q[0];
  assign TXRDY = txrdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: drives uart_tx_engine frames and compares every cycle of TX
// Latency: n/a (bench)
// Backpressure: n/a (bench)
module tb_uart_tx_engine;

  logic       clk;
  logic       rst;
  logic [3:0] baud;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       load;
  logic [7:0] out_port;
  logic       tx;
  logic       txrdy;

  int errors = 0;
  int checks = 0;

  int rate_tbl [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                        868, 434, 217, 109, 333333, 333333, 333333, 333333};

  uart_tx_engine dut (
    .clk      (clk),
    .rst      (rst),
    .baud     (baud),
    .EIGHT    (eight),
    .PEN      (pen),
    .OHEL     (ohel),
    .LOAD     (load),
    .OUT_PORT (out_port),
    .TX       (tx),
    .TXRDY    (txrdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame: start bit, data bits, optional parity, then stop ones.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                              input logic p, input logic o);
    bit q[$];
    int n;
    int ones;
    logic [10:0] f;
    n = e ? 8 : 7;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p) q.push_back(((ones % 2) == 1) ? ~o : o);
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  // Starts at a negedge with the engine idle; ends at the negedge of the first
  // TXRDY=1 cycle so a following call exercises back-to-back loading.
  // poke_k >= 0 injects a busy LOAD of 0x55 plus baud/OHEL changes at that cycle.
  // noise randomly strobes LOAD and churns the config inputs during the frame.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] b, input logic e,
                           input logic p, input logic o, input int poke_k,
                           input bit noise, input string tag);
    logic [10:0] exp_f;
    int rate;
    int nclk;
    bit bad_bit;
    bit bad_rdy;
    logic got_tx;
    exp_f = model_frame(d, e, p, o);
    rate  = rate_tbl[b];
    nclk  = 11 * rate;
    out_port = d; baud = b; eight = e; pen = p; ohel = o; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (noise) begin
      out_port = 8'($urandom); baud = 4'($urandom); eight = 1'($urandom);
      pen = 1'($urandom); ohel = 1'($urandom);
    end
    checks++;
    if (txrdy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s load_accept: txrdy=%b tx=%b, required txrdy=0 tx=1", tag, txrdy, tx);
    end
    bad_bit = 1'b0;
    bad_rdy = 1'b0;
    got_tx  = 1'b0;
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      if (tx !== exp_f[k / rate] && !bad_bit) begin
        bad_bit = 1'b1;
        got_tx  = tx;
      end
      if (txrdy !== 1'b0 && !bad_rdy) begin
        bad_rdy = 1'b1;
        $display("FAIL %s txrdy_busy: txrdy=%b at cycle %0d, required 0", tag, txrdy, k);
      end
      if ((k % rate) == rate - 1) begin
        checks++;
        if (bad_bit) begin
          errors++;
          $display("FAIL %s bit%0d: tx=%b, required %b", tag, k / rate, got_tx, exp_f[k / rate]);
        end
        bad_bit = 1'b0;
      end
      if (k == poke_k) begin
        load = 1'b1; out_port = 8'h55; baud = 4'h0; ohel = ~ohel;
      end else if (noise) begin
        load = ($urandom_range(0, 40) == 0);
        out_port = 8'($urandom); baud = 4'($urandom); ohel = 1'($urandom);
      end else begin
        load = 1'b0;
      end
    end
    checks++;
    if (bad_rdy) errors++;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (txrdy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_end: txrdy=%b tx=%b after %0d clocks, required txrdy=1 tx=1",
               tag, txrdy, tx, nclk);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ((tx !== 1'b1 || txrdy !== 1'b1) && !bad) begin
        bad = 1'b1;
        $display("FAIL %s idle: tx=%b txrdy=%b at cycle %0d, required tx=1 txrdy=1", tag, tx, txrdy, i);
      end
    end
    checks++;
    if (bad) errors++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; out_port = 8'h00; baud = 4'hB;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || txrdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_value: tx=%b txrdy=%b, required tx=1 txrdy=1", tx, txrdy);
    end
    rst = 1'b0;
    idle_check(500, "post_reset");
  endtask

  task automatic test_even8();
    run_frame(8'hA5, 4'hB, 1'b1, 1'b1, 1'b0, -1, 1'b0, "even8_A5");
    idle_check(5, "even8_gap");
  endtask

  task automatic test_odd7();
    run_frame(8'h41, 4'hB, 1'b0, 1'b1, 1'b1, -1, 1'b0, "odd7_41");
    idle_check(5, "odd7_gap");
  endtask

  task automatic test_no_parity();
    run_frame(8'hFF, 4'hB, 1'b1, 1'b0, 1'b0, -1, 1'b0, "nopar_FF");
    idle_check(5, "nopar_gap");
  endtask

  task automatic test_busy_load();
    run_frame(8'h3C, 4'hB, 1'b1, 1'b1, 1'b0, 300, 1'b0, "busy_load");
    idle_check(3 * 109, "busy_no_second");
  endtask

  task automatic test_back_to_back();
    run_frame(8'h12, 4'hB, 1'b1, 1'b1, 1'b0, -1, 1'b0, "b2b_12");
    run_frame(8'h34, 4'hB, 1'b1, 1'b1, 1'b0, -1, 1'b0, "b2b_34");
    idle_check(5, "b2b_gap");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_frame(8'($urandom), 4'(9 + $urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                1'($urandom), -1, 1'b1, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 20), $sformatf("rand%0d_gap", i));
    end
    idle_check(5, "rand_end");
  endtask

  task automatic test_reset_mid_frame();
    out_port = 8'h00; baud = 4'hB; eight = 1'b1; pen = 1'b0; ohel = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || txrdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_busy: tx=%b txrdy=%b, required tx=0 txrdy=0", tx, txrdy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || txrdy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: tx=%b txrdy=%b, required tx=1 txrdy=1", tx, txrdy);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_check(200, "after_mid_reset");
    run_frame(8'hC3, 4'hB, 1'b1, 1'b1, 1'b1, -1, 1'b0, "after_reset_frame");
  endtask

  initial begin
    test_reset();
    test_even8();
    test_odd7();
    test_no_parity();
    test_busy_load();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmit engine for the UART; pairs with the existing receive engine and uses the same baud select code and EIGHT/PEN framing controls.
- Accepts one byte per LOAD strobe from the processor-side write path and serialises it LSB-first: start bit, 7 or 8 data bits, optional parity, stop bits.
- Reports availability on TXRDY for use as a status bit and an interrupt source.

Parameters:
- FRAME_BITS, 11, number of bit times per frame, fixed. Unused trailing positions are transmitted as 1 (extra stop).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- baud  in  4  baud select code; same table as the receive engine
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
- PEN  in  1  parity enable
- OHEL  in  1  parity sense: 1 = odd, 0 = even
- LOAD  in  1  single-cycle write strobe for OUT_PORT
- OUT_PORT  in  8  byte to transmit
- TX  out  1  serial line, idle high
- TXRDY  out  1  1 = engine idle and able to accept LOAD

Behaviour:
- Reset values: TX=1, TXRDY=1. All counters, the shift register (all ones) and the state machine clear to the idle state.
- Bit time, in clocks, is selected from baud:
  - 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208
  - 6:2604, 7:1736, 8:868, 9:434, A:217, B:109
  - C–F: 333333
- baud, EIGHT, PEN, OHEL and OUT_PORT are latched on an accepted LOAD. Changes to them mid-frame have no effect until the next LOAD.
- LOAD is accepted only when TXRDY=1. LOAD while TXRDY=0 is ignored: no data corruption and no restart.
- Frame layout, bit0 sent first:
  - bit0 = 0 (start)
  - bits1–7 = data[6:0]
  - EIGHT=1: bit8 = data[7], bit9 = parity if PEN else 1, bit10 = 1
  - EIGHT=0: bit8 = parity if PEN else 1, bits9–10 = 1
- Parity: even = XOR of the transmitted data bits; odd = its inverse. Only the 7 data bits take part when EIGHT=0.
- State machine:
  - IDLE: TXRDY=1, TX=1. Accepted LOAD at edge n latches data and config; TXRDY=0 from n+1. Go to LOADSR.
  - LOADSR: one cycle. At edge n+2 the 11-bit shift register is loaded and TX=0 (start bit); the bit-time counter and bit counter clear. Go to SHIFT.
  - SHIFT: the bit-time counter increments each clock. When it reaches rate-1, BTU pulses for one clock: the register shifts right with 1 filled in, TX takes the next bit, the bit-time counter clears and the bit counter increments.
    - When the bit counter reaches 11, at the end of the stop-bit time, return to IDLE. TXRDY=1 and TX=1 on that same edge.
  - Each bit is held on TX for exactly rate clocks. Frame duration is 11 × rate clocks, from edge n+2 to TXRDY rising.
- Back-to-back: a LOAD accepted on the first cycle TXRDY=1 starts the next start bit 2 cycles later. There is no extra idle time beyond that.
- Counters: bit-time counter 19 bits; bit counter 4 bits, never exceeding 11.
- Reset mid-frame: TX returns to 1 and TXRDY to 1 immediately (asynchronous). The partial frame is abandoned.
- TX is driven directly from the shift-register LSB flop, so it is glitch-free.

Test Plan:
1. Reset, then idle 500 clocks -> TX=1 and TXRDY=1 throughout; rst asserted mid-frame forces TX=1 and TXRDY=1 within the same cycle.
2. baud=B, EIGHT=1, PEN=1, OHEL=0, LOAD 0xA5 -> TXRDY=0 next cycle; TX sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 109 clocks; TXRDY=1 exactly 1199 clocks after the start bit begins.
3. baud=B, EIGHT=0, PEN=1, OHEL=1, LOAD 0x41 -> TX 0,1,0,0,0,0,0,1,1(odd parity),1,1.
4. baud=B, EIGHT=1, PEN=0, LOAD 0xFF -> TX 0 followed by ten 1s; frame length 1199 clocks.
5. LOAD 0x55 while busy, then change baud and OHEL mid-frame -> the frame is unchanged, the second byte is not sent, and TXRDY returns per the original timing.
6. Back-to-back LOADs 0x12 then 0x34, the second on the first TXRDY=1 cycle -> second start bit begins 2 clocks after TXRDY rises; both frames are bit-exact.
